// File: rtl/net_boot_loader.sv
// rtl/net_boot_loader.sv - streams dmem stores, INSTR/REG/BAR/PC/NULL packets from image ROMs into core_flattened
// Optional running checksum of emitted words: define NET_BOOT_CHECKSUM_EN.
package net_boot_loader_pkg;
  typedef enum logic [2:0] {
    NULL  = 3'd0,
    INSTR = 3'd1,
    REG   = 3'd2,
    PC    = 3'd3,
    BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [9:0]  net_id;
    net_op_e     net_op;
    logic [4:0]  reserved;
    logic [31:0] net_data;
    logic [9:0]  net_addr;
  } net_packet_s;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;
endpackage

module net_boot_loader
  import net_boot_loader_pkg::*;
#(
  parameter int          dmem_words_p = 1024,
  parameter int          imem_words_p = 1024,
  parameter int          reg_words_p  = 64,
  parameter logic [9:0]  core_id_p    = 10'd1,
  parameter logic [31:0] bar_mask_p   = 32'h2,
  parameter logic [31:0] start_pc_p   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  output logic [1:0]  img_sel_o,
  output logic [9:0]  img_addr_o,
  input  logic [39:0] img_data_i,
  output net_packet_s net_packet_o,
  output mem_in_s     mem_o,
  output logic [31:0] dmem_addr_o,
  output logic        mem_select_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] checksum_o
);

  localparam int max_ab_lp    = (dmem_words_p > imem_words_p) ? dmem_words_p : imem_words_p;
  localparam int max_abc_lp   = (max_ab_lp > reg_words_p) ? max_ab_lp : reg_words_p;
  localparam int max_words_lp = (max_abc_lp > 0) ? max_abc_lp : 1;
  localparam int idx_w_lp     = $clog2(max_words_lp) + 1;

  localparam logic [idx_w_lp-1:0] idx_one_lp = idx_w_lp'(1);
  localparam logic [idx_w_lp-1:0] dmem_w_lp  = idx_w_lp'(dmem_words_p);
  localparam logic [idx_w_lp-1:0] imem_w_lp  = idx_w_lp'(imem_words_p);
  localparam logic [idx_w_lp-1:0] reg_w_lp   = idx_w_lp'(reg_words_p);

  typedef enum logic [2:0] {
    S_IDLE, S_DMEM, S_IMEM, S_REGS, S_BAR, S_PC, S_FIN, S_DONE
  } state_e;

  state_e                state_r, state_n, next_elem;
  logic [idx_w_lp-1:0]   index_r, index_n, elem_words;
  logic                  phase_r, phase_n;
  net_packet_s           pkt_n;
  mem_in_s               mem_n;
  logic [31:0]           daddr_n;
  logic                  sel_n, busy_n, done_n;
  logic                  emit_en, clear_sum;
  logic [31:0]           emit_data;

  function automatic net_packet_s mk_pkt(input net_op_e op, input logic [31:0] data,
                                         input logic [9:0] addr);
    net_packet_s p;
    p.net_id   = core_id_p;
    p.net_op   = op;
    p.reserved = '0;
    p.net_data = data;
    p.net_addr = addr;
    return p;
  endfunction

  assign img_addr_o = 10'(index_r);

  always_comb begin
    img_sel_o = 2'd0;
    case (state_r)
      S_IMEM:  img_sel_o = 2'd1;
      S_REGS:  img_sel_o = 2'd2;
      default: img_sel_o = 2'd0;
    endcase
  end

  always_comb begin
    state_n    = state_r;
    index_n    = index_r;
    phase_n    = phase_r;
    pkt_n      = mk_pkt(NULL, 32'h0, 10'd0);
    mem_n      = '0;
    daddr_n    = dmem_addr_o;
    sel_n      = mem_select_o;
    busy_n     = busy_o;
    done_n     = done_o;
    emit_en    = 1'b0;
    emit_data  = 32'h0;
    clear_sum  = 1'b0;
    elem_words = '0;
    next_elem  = S_IDLE;

    case (state_r)
      S_DMEM:  begin elem_words = dmem_w_lp; next_elem = S_IMEM; end
      S_IMEM:  begin elem_words = imem_w_lp; next_elem = S_REGS; end
      S_REGS:  begin elem_words = reg_w_lp;  next_elem = S_BAR;  end
      default: ;
    endcase

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_n   = S_DMEM;
          index_n   = '0;
          phase_n   = 1'b0;
          busy_n    = 1'b1;
          done_n    = 1'b0;
          sel_n     = 1'b0;
          clear_sum = 1'b1;
        end
      end
      S_DMEM, S_IMEM, S_REGS: begin
        // phase 0 presents the address, phase 1 consumes the ROM word returned for it
        if (elem_words == '0) begin
          state_n = next_elem;
        end else if (!phase_r) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          emit_en = 1'b1;
          if (index_r == elem_words - idx_one_lp) begin
            index_n = '0;
            state_n = next_elem;
          end else begin
            index_n = index_r + idx_one_lp;
          end
        end
        if (state_r == S_DMEM && state_n != S_DMEM) sel_n = 1'b1;
      end
      S_BAR: begin
        pkt_n   = mk_pkt(BAR, bar_mask_p, 10'd24);
        state_n = S_PC;
      end
      S_PC: begin
        pkt_n   = mk_pkt(PC, start_pc_p, 10'd0);
        state_n = S_FIN;
      end
      S_FIN: begin
        pkt_n   = mk_pkt(NULL, 32'hFFFF_FFFE, 10'd24);
        state_n = S_DONE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (emit_en) begin
      case (state_r)
        S_DMEM: begin
          emit_data        = img_data_i[31:0];
          mem_n.valid      = 1'b1;
          mem_n.wen        = 1'b1;
          mem_n.yumi       = 1'b1;
          mem_n.write_data = emit_data;
          daddr_n          = 32'(index_r) << 2;
        end
        S_IMEM: begin
          emit_data = {16'b0, img_data_i[15:0]};
          pkt_n     = mk_pkt(INSTR, emit_data, 10'(index_r));
        end
        S_REGS: begin
          emit_data = img_data_i[31:0];
          pkt_n     = mk_pkt(REG, emit_data, {4'b0, img_data_i[37:32]});
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      index_r      <= '0;
      phase_r      <= 1'b0;
      net_packet_o <= mk_pkt(NULL, 32'h0, 10'd0);
      mem_o        <= '0;
      dmem_addr_o  <= '0;
      mem_select_o <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_r      <= state_n;
      index_r      <= index_n;
      phase_r      <= phase_n;
      net_packet_o <= pkt_n;
      mem_o        <= mem_n;
      dmem_addr_o  <= daddr_n;
      mem_select_o <= sel_n;
      busy_o       <= busy_n;
      done_o       <= done_n;
    end
  end

  logic unused_img_bits;
  assign unused_img_bits = ^img_data_i[39:38];

`ifdef NET_BOOT_CHECKSUM_EN
  logic [31:0] checksum_r;
  always_ff @(posedge clk) begin
    if (reset || clear_sum) checksum_r <= '0;
    else if (emit_en)       checksum_r <= checksum_r + emit_data;
  end
  assign checksum_o = checksum_r;
`else
  logic unused_sum_bits;
  assign unused_sum_bits = ^{clear_sum, emit_en, emit_data};
  assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_net_boot_loader.sv
// tb/tb_net_boot_loader.sv - directed bench for net_boot_loader with a 2/2/1 word image
module tb_net_boot_loader;
  import net_boot_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  img_sel_o;
  logic [9:0]  img_addr_o;
  logic [39:0] img_data_i;
  net_packet_s net_packet_o;
  mem_in_s     mem_o;
  logic [31:0] dmem_addr_o;
  logic        mem_select_o, busy_o, done_o;
  logic [31:0] checksum_o;

  int total = 0;
  int bad = 0;

  net_packet_s pkt_c   [0:17];
  mem_in_s     mem_c   [0:17];
  logic [31:0] daddr_c [0:17];
  logic [31:0] sum_c   [0:17];
  logic        sel_c   [0:17];
  logic        busy_c  [0:17];
  logic        done_c  [0:17];

  always #5 clk = ~clk;

  net_boot_loader #(
    .dmem_words_p(2), .imem_words_p(2), .reg_words_p(1),
    .core_id_p(10'd1), .bar_mask_p(32'h2), .start_pc_p(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .img_sel_o(img_sel_o), .img_addr_o(img_addr_o), .img_data_i(img_data_i),
    .net_packet_o(net_packet_o), .mem_o(mem_o), .dmem_addr_o(dmem_addr_o),
    .mem_select_o(mem_select_o), .busy_o(busy_o), .done_o(done_o),
    .checksum_o(checksum_o)
  );

  // synchronous image ROMs; upper junk bits must be ignored by the loader
  always @(posedge clk) begin
    case (img_sel_o)
      2'd0:    img_data_i <= (img_addr_o == 10'd0) ? 40'h3C_AAAA0000 : 40'h3C_BBBB1111;
      2'd1:    img_data_i <= (img_addr_o == 10'd0) ? 40'hFF_ABCD1234 : 40'hFF_ABCD5678;
      default: img_data_i <= 40'hC5_00000007;
    endcase
  end

  function automatic net_packet_s mk(input net_op_e op, input logic [31:0] d, input logic [9:0] a);
    net_packet_s p;
    p.net_id = 10'd1; p.net_op = op; p.reserved = 5'd0; p.net_data = d; p.net_addr = a;
    return p;
  endfunction

  // expected packet in cycle k, where cycle 0 is the cycle start_i is high
  function automatic net_packet_s exp_pkt(input int k);
    case (k)
      7:       return mk(INSTR, 32'h1234, 10'd0);
      9:       return mk(INSTR, 32'h5678, 10'd1);
      11:      return mk(REG,   32'h7,    10'd5);
      12:      return mk(BAR,   32'h2,    10'd24);
      13:      return mk(PC,    32'h0,    10'd0);
      14:      return mk(NULL,  32'hFFFFFFFE, 10'd24);
      default: return mk(NULL,  32'h0,    10'd0);
    endcase
  endfunction

  task automatic run_capture(input int restart_k);
    @(negedge clk);
    start_i = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      pkt_c[k] = net_packet_o; mem_c[k] = mem_o; daddr_c[k] = dmem_addr_o;
      sel_c[k] = mem_select_o; busy_c[k] = busy_o; done_c[k] = done_o; sum_c[k] = checksum_o;
      start_i = (k == restart_k);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (net_packet_o !== mk(NULL, 32'h0, 10'd0)) begin
        bad++; $display("FAIL reset_pkt got=%h exp=%h", net_packet_o, mk(NULL, 32'h0, 10'd0));
      end
    end
    total++;
    if (mem_o !== '0) begin bad++; $display("FAIL reset_mem got=%h exp=0", mem_o); end
    total++;
    if ({mem_select_o, busy_o, done_o} !== 3'b100) begin
      bad++; $display("FAIL reset_flags got=%b exp=100", {mem_select_o, busy_o, done_o});
    end
    total++;
    if (checksum_o !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h exp=0", checksum_o); end
  endtask

  task automatic test_dmem_stores;
    run_capture(0);
    for (int k = 1; k <= 17; k++) begin
      logic ev, es;
      ev = (k == 3 || k == 5);
      es = !(k >= 1 && k <= 4);
      total++;
      if (mem_c[k].valid !== ev) begin
        bad++; $display("FAIL store_valid k=%0d got=%b exp=%b", k, mem_c[k].valid, ev);
      end
      total++;
      if (sel_c[k] !== es) begin
        bad++; $display("FAIL mem_select k=%0d got=%b exp=%b", k, sel_c[k], es);
      end
      if (ev) begin
        mem_in_s em;
        em.valid = 1'b1; em.wen = 1'b1; em.yumi = 1'b1; em.byte_not_word = 1'b0;
        em.write_data = (k == 3) ? 32'hAAAA0000 : 32'hBBBB1111;
        total++;
        if (mem_c[k] !== em) begin
          bad++; $display("FAIL store_word k=%0d got=%h exp=%h", k, mem_c[k], em);
        end
        total++;
        if (daddr_c[k] !== ((k == 3) ? 32'd0 : 32'd4)) begin
          bad++; $display("FAIL store_addr k=%0d got=%h exp=%h", k, daddr_c[k], (k == 3) ? 32'd0 : 32'd4);
        end
      end
    end
  endtask

  task automatic test_net_packets;
    for (int k = 1; k <= 17; k++) begin
      total++;
      if (pkt_c[k] !== exp_pkt(k)) begin
        bad++; $display("FAIL packet k=%0d got=%h exp=%h", k, pkt_c[k], exp_pkt(k));
      end
      total++;
      if ({busy_c[k], done_c[k]} !== {k <= 13, k >= 14}) begin
        bad++; $display("FAIL busy_done k=%0d got=%b%b exp=%b%b", k, busy_c[k], done_c[k], k <= 13, k >= 14);
      end
    end
  endtask

  task automatic test_checksum;
    logic [31:0] exp_sum;
`ifdef NET_BOOT_CHECKSUM_EN
    exp_sum = 32'hAAAA0000 + 32'hBBBB1111 + 32'h1234 + 32'h5678 + 32'h7;
`else
    exp_sum = 32'h0;
`endif
    for (int k = 14; k <= 17; k++) begin
      total++;
      if (sum_c[k] !== exp_sum) begin
        bad++; $display("FAIL checksum k=%0d got=%h exp=%h", k, sum_c[k], exp_sum);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (checksum_o !== exp_sum) begin
      bad++; $display("FAIL checksum_hold got=%h exp=%h", checksum_o, exp_sum);
    end
  endtask

  task automatic test_back_to_back;
    for (int pass = 0; pass < 2; pass++) begin
      run_capture(pass == 0 ? 7 : 0);
      for (int k = 1; k <= 17; k++) begin
        total++;
        if (pkt_c[k] !== exp_pkt(k) || done_c[k] !== (k >= 14) || mem_c[k].valid !== (k == 3 || k == 5)) begin
          bad++;
          $display("FAIL rerun%0d k=%0d got=%h/%b/%b exp=%h/%b/%b", pass, k, pkt_c[k], done_c[k],
                   mem_c[k].valid, exp_pkt(k), k >= 14, k == 3 || k == 5);
        end
      end
    end
  endtask

  task automatic test_reset_mid_regs;
    @(negedge clk);
    start_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (k == 9) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (net_packet_o !== mk(NULL, 32'h0, 10'd0) || mem_o !== '0) begin
      bad++; $display("FAIL midreset_out got=%h/%h exp=%h/0", net_packet_o, mem_o, mk(NULL, 32'h0, 10'd0));
    end
    total++;
    if ({mem_select_o, busy_o, done_o} !== 3'b100) begin
      bad++; $display("FAIL midreset_flags got=%b exp=100", {mem_select_o, busy_o, done_o});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (net_packet_o.net_op !== NULL || busy_o !== 1'b0) begin
        bad++; $display("FAIL midreset_quiet i=%0d got=%0d/%b exp=0/0", i, net_packet_o.net_op, busy_o);
      end
    end
    run_capture(0);
    for (int k = 1; k <= 17; k++) begin
      total++;
      if (pkt_c[k] !== exp_pkt(k) || done_c[k] !== (k >= 14)) begin
        bad++; $display("FAIL reload k=%0d got=%h/%b exp=%h/%b", k, pkt_c[k], done_c[k], exp_pkt(k), k >= 14);
      end
    end
  endtask

  initial begin
    test_reset;
    test_dmem_stores;
    test_net_packets;
    test_checksum;
    test_back_to_back;
    test_reset_mid_regs;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
